// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings for the hazard controller
// Purpose: operand-forwarding source codes, mul/div FSM states and the
//          width of the mul/div occupancy counter.
// Ports:   none (package).
package hazard_pkg;

  // Operand source selection driven onto fwd_a / fwd_b.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EXE = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_e;

  // Mul/div occupancy FSM.
  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // Holds MD_LAT-1 for any legal latency (2..15).
  localparam int MD_CNT_W = 4;

endpackage

// File: rtl/fwd_sel.sv
// rtl/fwd_sel.sv - forwarding source selector for one operand
// Purpose: picks the youngest in-flight producer of a source register,
//          priority EXE (non-load) > MEM > WB; register 0 never forwards.
// Ports:
//   src                  in  AW  source register address in ID
//   exe_addr/exe_wen     in      EXE writeback target / enable
//   exe_is_load          in      EXE holds a load (data not ready yet)
//   mem_addr/mem_wen     in      MEM writeback target / enable
//   wb_addr/wb_wen       in      WB writeback target / enable
//   sel                  out 2   FWD_RF / FWD_EXE / FWD_MEM / FWD_WB
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] exe_addr,
  input  logic          exe_wen,
  input  logic          exe_is_load,
  input  logic [AW-1:0] mem_addr,
  input  logic          mem_wen,
  input  logic [AW-1:0] wb_addr,
  input  logic          wb_wen,
  output logic [1:0]    sel
);

  logic src_nz;

  assign src_nz = (src != '0);

  always_comb begin
    sel = FWD_RF;
    if (src_nz) begin
      if (exe_wen && !exe_is_load && (src == exe_addr)) begin
        sel = FWD_EXE;
      end else if (mem_wen && (src == mem_addr)) begin
        sel = FWD_MEM;
      end else if (wb_wen && (src == wb_addr)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller (forwarding, stalls, flushes)
// Purpose: combinational operand forwarding, load-use stall, store-data
//          forwarding flag, memory-wait freeze, mul/div occupancy FSM,
//          branch flush and a saturating stall counter.
// Optional: HAZARD_DEBUG_STEP_EN adds debug_en / debug_step single-step hold.
// Ports:
//   clk, rst                       clock (rising), async active-low reset
//   debug_en, debug_step           single-step control (optional build only)
//   id_rs, id_rt, *_used           ID source registers and use qualifiers
//   id_is_store/is_md/branch_taken ID decode qualifiers
//   {exe,mem,wb}_wb_addr/_wen      writeback target per stage
//   exe_is_load, mem_is_load       stage holds a load
//   mem_ready                      load data valid in MEM this cycle
//   fwd_a, fwd_b, fwd_m            operand / store-data forwarding selects
//   *_en, *_flush                  stage enables and bubble inserts
//   md_busy, md_done, stall_cnt    mul/div status and stall counter
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int AW     = 5,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
`ifdef HAZARD_DEBUG_STEP_EN
  input  logic             debug_en,
  input  logic             debug_step,
`endif
  input  logic [AW-1:0]    id_rs,
  input  logic [AW-1:0]    id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             id_is_store,
  input  logic             id_is_md,
  input  logic             id_branch_taken,
  input  logic [AW-1:0]    exe_wb_addr,
  input  logic             exe_wb_wen,
  input  logic [AW-1:0]    mem_wb_addr,
  input  logic             mem_wb_wen,
  input  logic [AW-1:0]    wb_wb_addr,
  input  logic             wb_wb_wen,
  input  logic             exe_is_load,
  input  logic             mem_is_load,
  input  logic             mem_ready,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             fwd_m,
  output logic             if_en,
  output logic             id_en,
  output logic             exe_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic             if_flush,
  output logic             exe_flush,
  output logic             mem_flush,
  output logic             wb_flush,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [1:0]          sel_a, sel_b;
  logic                exe_load_nz, load_use, store_fwd, mem_wait;
  logic                dbg_hold, md_frozen;
  md_state_e           state, state_nxt;
  logic [MD_CNT_W-1:0] md_cnt;

  fwd_sel #(.AW(AW)) u_fwd_a (
    .src(id_rs), .exe_addr(exe_wb_addr), .exe_wen(exe_wb_wen),
    .exe_is_load(exe_is_load), .mem_addr(mem_wb_addr), .mem_wen(mem_wb_wen),
    .wb_addr(wb_wb_addr), .wb_wen(wb_wb_wen), .sel(sel_a)
  );

  fwd_sel #(.AW(AW)) u_fwd_b (
    .src(id_rt), .exe_addr(exe_wb_addr), .exe_wen(exe_wb_wen),
    .exe_is_load(exe_is_load), .mem_addr(mem_wb_addr), .mem_wen(mem_wb_wen),
    .wb_addr(wb_wb_addr), .wb_wen(wb_wb_wen), .sel(sel_b)
  );

  assign fwd_a = rst ? sel_a : FWD_RF;
  assign fwd_b = rst ? sel_b : FWD_RF;

  // A load to $0 produces nothing worth waiting for.
  assign exe_load_nz = exe_is_load && exe_wb_wen && (exe_wb_addr != '0);
  assign load_use    = exe_load_nz &&
                       ((id_rs_used && (id_rs == exe_wb_addr)) ||
                        (id_rt_used && !id_is_store && (id_rt == exe_wb_addr)));
  // Store data is only needed in MEM, so it can take the load result there.
  assign store_fwd   = exe_load_nz && id_is_store && (id_rt == exe_wb_addr);
  assign mem_wait    = mem_is_load && !mem_ready;

`ifdef HAZARD_DEBUG_STEP_EN
  logic step_q1, step_q2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_q1 <= 1'b0;
      step_q2 <= 1'b0;
    end else begin
      step_q1 <= debug_step;
      step_q2 <= step_q1;
    end
  end

  assign dbg_hold = debug_en && !(step_q1 && !step_q2);
`else
  assign dbg_hold = 1'b0;
`endif

  assign md_frozen = dbg_hold || mem_wait;

  // FSM state register and occupancy counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= MD_IDLE;
      md_cnt <= '0;
    end else begin
      state <= state_nxt;
      if ((state == MD_IDLE) && (state_nxt == MD_BUSY)) begin
        md_cnt <= MD_CNT_W'(MD_LAT - 1);
      end else if ((state == MD_BUSY) && !md_frozen && (md_cnt != '0)) begin
        md_cnt <= md_cnt - 1'b1;
      end
    end
  end

  // FSM next state: a mul/div enters BUSY only when it actually leaves ID.
  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE: if (id_is_md && id_en && rst) state_nxt = MD_BUSY;
      MD_BUSY: if (!md_frozen && (md_cnt == '0)) state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
  end

  // FSM / pipeline outputs, highest-priority cause first.
  always_comb begin
    if_en     = 1'b1;
    id_en     = 1'b1;
    exe_en    = 1'b1;
    mem_en    = 1'b1;
    wb_en     = 1'b1;
    if_flush  = 1'b0;
    exe_flush = 1'b0;
    mem_flush = 1'b0;
    wb_flush  = 1'b0;
    if (!rst) begin
      if_flush  = 1'b1;
      exe_flush = 1'b1;
      mem_flush = 1'b1;
      wb_flush  = 1'b1;
    end else if (dbg_hold) begin
      if_en  = 1'b0;
      id_en  = 1'b0;
      exe_en = 1'b0;
      mem_en = 1'b0;
      wb_en  = 1'b0;
    end else if (mem_wait) begin
      if_en    = 1'b0;
      id_en    = 1'b0;
      exe_en   = 1'b0;
      mem_en   = 1'b0;
      wb_flush = 1'b1;
    end else if (state == MD_BUSY) begin
      if_en     = 1'b0;
      id_en     = 1'b0;
      exe_en    = 1'b0;
      mem_flush = 1'b1;
    end else if (load_use) begin
      if_en     = 1'b0;
      id_en     = 1'b0;
      exe_flush = 1'b1;
    end else if (id_branch_taken) begin
      if_flush = 1'b1;
    end
    md_busy = rst && (state == MD_BUSY);
    md_done = rst && (state == MD_BUSY) && !md_frozen && (md_cnt == '0);
  end

  // fwd_m follows the store into EXE; it holds while EXE is frozen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_m <= 1'b0;
    end else if (exe_en) begin
      fwd_m <= store_fwd && id_en;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if ((load_use || mem_wait || (state == MD_BUSY)) && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, exe_wb_addr, mem_wb_addr, wb_wb_addr;
  logic        id_rs_used, id_rt_used, id_is_store, id_is_md, id_branch_taken;
  logic        exe_wb_wen, mem_wb_wen, wb_wb_wen;
  logic        exe_is_load, mem_is_load, mem_ready;
  logic [1:0]  fwd_a, fwd_b;
  logic        fwd_m;
  logic        if_en, id_en, exe_en, mem_en, wb_en;
  logic        if_flush, exe_flush, mem_flush, wb_flush;
  logic        md_busy, md_done;
  logic [15:0] stall_cnt;
`ifdef HAZARD_DEBUG_STEP_EN
  logic        debug_en = 1'b0;
  logic        debug_step = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
`ifdef HAZARD_DEBUG_STEP_EN
    .debug_en(debug_en), .debug_step(debug_step),
`endif
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_is_store(id_is_store), .id_is_md(id_is_md), .id_branch_taken(id_branch_taken),
    .exe_wb_addr(exe_wb_addr), .exe_wb_wen(exe_wb_wen),
    .mem_wb_addr(mem_wb_addr), .mem_wb_wen(mem_wb_wen),
    .wb_wb_addr(wb_wb_addr), .wb_wb_wen(wb_wb_wen),
    .exe_is_load(exe_is_load), .mem_is_load(mem_is_load), .mem_ready(mem_ready),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_m(fwd_m),
    .if_en(if_en), .id_en(id_en), .exe_en(exe_en), .mem_en(mem_en), .wb_en(wb_en),
    .if_flush(if_flush), .exe_flush(exe_flush), .mem_flush(mem_flush), .wb_flush(wb_flush),
    .md_busy(md_busy), .md_done(md_done), .stall_cnt(stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
    id_is_store = 0; id_is_md = 0; id_branch_taken = 0;
    exe_wb_addr = 0; exe_wb_wen = 0; mem_wb_addr = 0; mem_wb_wen = 0;
    wb_wb_addr = 0; wb_wb_wen = 0;
    exe_is_load = 0; mem_is_load = 0; mem_ready = 1;
  endtask

  // Advance past the next rising edge; inputs are then driven and checked
  // after a further #1 so the combinational outputs have settled.
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    id_rs = 1; id_rs_used = 1; exe_wb_addr = 1; exe_wb_wen = 1;
    #3;
    check("rst_if_flush", if_flush, 1);
    check("rst_wb_flush", wb_flush, 1);
    check("rst_if_en", if_en, 1);
    check("rst_fwd_a", fwd_a, 0);
    check("rst_md_busy", md_busy, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    next_cyc();
    rst = 1'b1;
    idle_inputs();
    #1;
    check("idle_if_en", if_en, 1);
    check("idle_flush", {if_flush, exe_flush, mem_flush, wb_flush}, 0);
    check("idle_fwd", {fwd_a, fwd_b, fwd_m}, 0);

    // add $3,$1,$2 with EXE writing $1 (ALU) and MEM writing $2
    next_cyc();
    id_rs = 1; id_rt = 2; id_rs_used = 1; id_rt_used = 1;
    exe_wb_addr = 1; exe_wb_wen = 1; mem_wb_addr = 2; mem_wb_wen = 1;
    #1;
    check("alu_fwd_a", fwd_a, 2'b01);
    check("alu_fwd_b", fwd_b, 2'b10);
    check("alu_no_stall", {if_en, id_en}, 2'b11);

    // MEM beats WB, WB alone selects 11
    next_cyc();
    idle_inputs();
    id_rs = 4; id_rt = 6; id_rs_used = 1; id_rt_used = 1;
    mem_wb_addr = 4; mem_wb_wen = 1; wb_wb_addr = 4; wb_wb_wen = 1;
    #1;
    check("mem_over_wb", fwd_a, 2'b10);
    wb_wb_addr = 6;
    #1;
    check("wb_only", fwd_b, 2'b11);

    // lw $5 in EXE, sw $5 in ID: no stall, fwd_m one cycle later
    next_cyc();
    idle_inputs();
    id_rt = 5; id_rt_used = 1; id_is_store = 1;
    exe_wb_addr = 5; exe_wb_wen = 1; exe_is_load = 1;
    #1;
    check("st_no_stall", {if_en, exe_flush}, 2'b10);
    check("st_fwd_b_not_exe", fwd_b, 2'b00);
    next_cyc();
    idle_inputs();
    #1;
    check("st_fwd_m", fwd_m, 1);
    next_cyc();
    #1;
    check("st_fwd_m_clear", fwd_m, 0);

    // lw $5 in EXE, add uses $5: one bubble, then forward from MEM
    next_cyc();
    idle_inputs();
    id_rs = 5; id_rs_used = 1; exe_wb_addr = 5; exe_wb_wen = 1; exe_is_load = 1;
    #1;
    check("lu_if_id_en", {if_en, id_en}, 2'b00);
    check("lu_exe_flush", exe_flush, 1);
    check("lu_cnt_before", stall_cnt, 0);
    next_cyc();
    idle_inputs();
    id_rs = 5; id_rs_used = 1; mem_wb_addr = 5; mem_wb_wen = 1; mem_is_load = 1;
    #1;
    check("lu_after_en", if_en, 1);
    check("lu_after_fwd", fwd_a, 2'b10);
    check("lu_cnt_after", stall_cnt, 1);

    // branch flushes only when ID advances
    next_cyc();
    idle_inputs();
    id_branch_taken = 1;
    #1;
    check("br_flush", if_flush, 1);
    id_rs = 7; id_rs_used = 1; exe_wb_addr = 7; exe_wb_wen = 1; exe_is_load = 1;
    #1;
    check("br_under_lu", if_flush, 0);

    // $0 in every stage never forwards
    next_cyc();
    idle_inputs();
    id_rs_used = 1; id_rt_used = 1;
    exe_wb_wen = 1; mem_wb_wen = 1; wb_wb_wen = 1;
    #1;
    check("r0_fwd", {fwd_a, fwd_b}, 0);
    check("r0_cnt", stall_cnt, 2);

    // memory wait for two cycles
    for (int k = 0; k < 2; k++) begin
      next_cyc();
      idle_inputs();
      mem_is_load = 1; mem_ready = 0;
      #1;
      check("mw_en", {if_en, id_en, exe_en, mem_en, wb_en}, 5'b00001);
      check("mw_wb_flush", wb_flush, 1);
    end

    // mul, MD_LAT=4, no interruptions
    next_cyc();
    idle_inputs();
    id_is_md = 1;
    #1;
    check("md_issue_busy", md_busy, 0);
    check("md_issue_cnt", stall_cnt, 4);
    for (int k = 1; k <= 4; k++) begin
      next_cyc();
      idle_inputs();
      #1;
      check("md_busy", md_busy, 1);
      check("md_done", md_done, (k == 4) ? 1 : 0);
      check("md_hold", {if_en, exe_en, mem_flush}, 3'b001);
    end
    next_cyc();
    #1;
    check("md_end_busy", {md_busy, md_done}, 0);
    check("md_end_cnt", stall_cnt, 8);

    // mul with memory wait in busy cycles 2 and 3: busy lasts 6
    idle_inputs();
    id_is_md = 1;
    for (int k = 1; k <= 6; k++) begin
      next_cyc();
      idle_inputs();
      if (k == 2 || k == 3) begin
        mem_is_load = 1; mem_ready = 0;
      end
      #1;
      check("mdw_busy", md_busy, 1);
      check("mdw_done", md_done, (k == 6) ? 1 : 0);
    end
    next_cyc();
    #1;
    check("mdw_end_busy", md_busy, 0);
    check("mdw_end_cnt", stall_cnt, 14);

    // reset mid-BUSY
    id_is_md = 1;
    next_cyc();
    idle_inputs();
    #1;
    check("rb_busy", md_busy, 1);
    rst = 1'b0;
    #1;
    check("rb_busy_now", md_busy, 0);
    check("rb_done", md_done, 0);
    check("rb_cnt", stall_cnt, 0);
    next_cyc();
    rst = 1'b1;
    #1;
    check("rb_idle", md_busy, 0);
    check("rb_if_en", if_en, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
